// File: rtl/cla_mult_pkg.sv
// Shared types and constants for the carry-lookahead shift-and-add multiplier.
package cla_mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned CLA_GROUP = 4;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/cla_adder_w.sv
// WIDTH-bit combinational carry-lookahead adder built from 4-bit lookahead groups.
// Group carries ripple between groups; carries inside a group are fully looked ahead.
module cla_adder_w
  import cla_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int unsigned NGroups = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g    = a & b;
  assign p    = a | b;
  assign c[0] = ci;

  for (genvar k = 0; k < NGroups; k++) begin : g_grp
    localparam int unsigned Base = k * CLA_GROUP;
    logic [3:0] gg;
    logic [3:0] pp;
    logic       cin;
    logic       grp_g;
    logic       grp_p;

    assign gg  = g[Base +: 4];
    assign pp  = p[Base +: 4];
    assign cin = c[Base];

    assign c[Base+1] = gg[0] | (pp[0] & cin);
    assign c[Base+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
    assign c[Base+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & cin);

    assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p = &pp;
    assign c[Base+4] = grp_g | (grp_p & cin);
  end

  // p = a|b is a valid propagate for carries, but the sum bit still needs a^b.
  assign s  = a ^ b ^ c[WIDTH-1:0];
  assign co = c[WIDTH];

endmodule

// File: rtl/cla_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier with a CLA datapath adder.
// Define CLA_MULT_EARLY_TERM_EN to finish as soon as no multiplier bits remain.
module cla_shift_add_mult
  import cla_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mq_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] result;
  logic               last;

  assign addend = mq_q[0] ? mcand_q : '0;

  cla_adder_w #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a (acc_q),
    .b (addend),
    .ci(1'b0),
    .s (sum),
    .co(carry)
  );

  // The carry-out becomes the new acc MSB, so the product can never overflow.
  assign shifted = {carry, sum, mq_q[WIDTH-1:1]};

`ifdef CLA_MULT_EARLY_TERM_EN
  logic rest;

  // Only the low cnt bits of mq still hold multiplier bits; the rest is product.
  always_comb begin
    last   = (cnt_q == CNT_W'(1));
    result = shifted;
    rest   = 1'b0;
    for (int i = 1; i < int'(WIDTH); i++) begin
      if (CNT_W'(i) < cnt_q) rest = rest | mq_q[i];
    end
    if (!rest) begin
      last   = 1'b1;
      result = shifted >> (cnt_q - CNT_W'(1));
    end
  end
`else
  always_comb begin
    last   = (cnt_q == CNT_W'(1));
    result = shifted;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            mcand_q <= a;
            mq_q    <= b;
            acc_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          {acc_q, mq_q} <= shifted;
          cnt_q         <= cnt_q - CNT_W'(1);
          if (last) begin
            product_q <= result;
            state_q   <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_cla_shift_add_mult.sv
// Scoreboard bench for cla_shift_add_mult (WIDTH=4 main instance, WIDTH=8 spot check).
module tb_cla_shift_add_mult;

  localparam int unsigned W = 4;

  typedef struct {
    logic [2*W-1:0] prod;
    int             k;
    int             lat;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  logic           start8;
  logic [7:0]     a8;
  logic [7:0]     b8;
  logic           busy8;
  logic           done8;
  logic [15:0]    product8;

  int             checks;
  int             failures;
  int             cyc;
  exp_t           sb[$];
  logic [2*W-1:0] held;

  cla_shift_add_mult #(
    .WIDTH(W)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  cla_shift_add_mult #(
    .WIDTH(8)
  ) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .product(product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] bv);
    int lat;
    lat = W;
`ifdef CLA_MULT_EARLY_TERM_EN
    lat = 1;
    for (int i = 0; i < int'(W); i++) if (bv[i]) lat = i + 1;
`endif
    return lat;
  endfunction

  // Caller is at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.prod = (2*W)'(av) * (2*W)'(bv);
    e.k    = cyc + 1;
    e.lat  = exp_lat(bv);
    sb.push_back(e);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for done, got busy=%0d expected done=1", name, busy);
  endtask

  // Monitor: pops on every done, otherwise checks the product is held.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got done=1 product=%0d expected no done", product);
      end else begin
        e = sb.pop_front();
        check("product", longint'(product), longint'(e.prod));
        check("latency", longint'(cyc - e.k), longint'(e.lat));
        check("busy_at_done", longint'(busy), 0);
        held = e.prod;
      end
    end else begin
      check("product_held", longint'(product), longint'(held));
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    held     = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    start8   = 1'b0;
    a8       = '0;
    b8       = '0;

    #12;
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_product", longint'(product), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd15, 4'd15);
    check("busy_after_start", longint'(busy), 1);
    wait_done("mul_15x15");
    @(negedge clk);

    // Reset while running: everything clears at once and no done follows.
    a     = 4'd9;
    b     = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrun_busy_before", longint'(busy), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", longint'(busy), 0);
    check("midrun_reset_done", longint'(done), 0);
    check("midrun_reset_product", longint'(product), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_done_after_reset", longint'(done), 0);
    end

    // start while busy must be ignored even with new operands.
    issue(4'd6, 4'd11);
    a     = 4'd1;
    b     = 4'd1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_6x11");
    @(negedge clk);
    @(negedge clk);

    issue(4'd3, 4'd5);
    wait_done("b2b_first");
    issue(4'd12, 4'd10);
    wait_done("b2b_second");
    @(negedge clk);

    issue(4'd0, 4'd13);
    wait_done("zero_a");
    @(negedge clk);
    issue(4'd13, 4'd0);
    wait_done("zero_b");
    @(negedge clk);
    issue(4'd7, 4'd2);
    wait_done("mul_7x2");
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      wait_done("random");
      if (n % 3 == 0) @(negedge clk);
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d outstanding expected 0", sb.size());
    end

    a8     = 8'd255;
    b8     = 8'd255;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    begin : wait8
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done8) disable wait8;
      end
    end
    check("w8_done", longint'(done8), 1);
    check("w8_product", longint'(product8), 65025);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
